// File: rtl/pixel_link_pkg.sv
// pixel_link_pkg
// Shared definitions for the pooled-pixel serial link: the transmit state
// encoding and the default line timing / frame geometry constants.
// No ports; imported by pixel_serializer.

package pixel_link_pkg;

  // Transmit FSM states: line idle, start bit, eight data bits, stop bit
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // 115200 baud from a 200 MHz clock
  localparam int DEFAULT_CLKS_PER_BIT = 1736;

  // 31x31 image after stride-2 pooling
  localparam int DEFAULT_FRAME_PIXELS = 961;

  // Input buffer entries; must be a power of two so the pointers wrap freely
  localparam int DEFAULT_FIFO_DEPTH = 4;

endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo
// Small synchronous FIFO buffering pixels between the pooling stage and the
// serial transmitter. DEPTH must be a power of two (>= 2).
// Ports:
//   clk      - rising-edge clock
//   reset    - synchronous active-high reset, empties the buffer
//   push     - write wr_data this edge (ignored when full)
//   pop      - drop the head entry this edge (ignored when empty)
//   wr_data  - entry to write
//   rd_data  - current head entry (valid while not empty)
//   full     - occupancy equals DEPTH
//   empty    - occupancy is zero

module pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  // Guard both ports here so a misbehaving neighbour can never overflow or
  // underflow the buffer.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; the separate
  // occupancy count distinguishes full from empty when the pointers meet.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_serializer.sv
// pixel_serializer
// Buffers pooled pixels and sends each one as an 8N1 serial character
// (start bit, 8 data bits LSB first, stop bit), counting pixels per frame.
// Ports:
//   clk_200mhz  - single rising-edge clock
//   reset       - synchronous active-high reset, aborts any character
//   pixel_in    - pooled pixel from the pooling stage
//   valid_in    - pixel_in is valid
//   ready_out   - buffer can accept a pixel this edge
//   tx_serial   - registered serial line, idles high
//   tx_busy     - a character is on the line or pixels are still buffered
//   frame_done  - one-cycle pulse when the last pixel of a frame finishes
//   pixel_count - pixels fully transmitted in the current frame

module pixel_serializer #(
  parameter int CLKS_PER_BIT = pixel_link_pkg::DEFAULT_CLKS_PER_BIT,
  parameter int FRAME_PIXELS = pixel_link_pkg::DEFAULT_FRAME_PIXELS,
  parameter int FIFO_DEPTH   = pixel_link_pkg::DEFAULT_FIFO_DEPTH
) (
  input  logic       clk_200mhz,
  input  logic       reset,
  input  logic [7:0] pixel_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       frame_done,
  output logic [9:0] pixel_count
);

  import pixel_link_pkg::*;

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [9:0]        FRAME_LAST = 10'(FRAME_PIXELS - 1);

  tx_state_t         state;
  tx_state_t         state_n;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BAUD_W-1:0] baud_n;
  logic [2:0]        bit_idx;
  logic [2:0]        bit_n;
  logic [7:0]        shift_reg;
  logic [7:0]        shift_n;
  logic              tx_n;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [7:0]        fifo_data;
  logic              char_done;

  // ready_out comes only from registered occupancy, so there is no
  // combinational path from valid_in back to the pooling stage.
  assign ready_out = !fifo_full;
  assign tx_busy   = (state != IDLE) || !fifo_empty;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk_200mhz),
    .reset   (reset),
    .push    (valid_in && ready_out),
    .pop     (fifo_pop),
    .wr_data (pixel_in),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Transmit state register. The line itself is registered from the value
  // the next state will drive, so the start bit appears right after the pop.
  always_ff @(posedge clk_200mhz) begin
    if (reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx_serial <= 1'b1;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_idx   <= bit_n;
      shift_reg <= shift_n;
      tx_serial <= tx_n;
    end
  end

  // Next-state logic. Each of START/DATA/STOP holds for CLKS_PER_BIT cycles;
  // DATA shifts the byte right so bit 0 of shift_reg is always the bit on
  // the line. IDLE pops the FIFO head the first cycle it is non-empty.
  always_comb begin
    state_n   = state;
    baud_n    = baud_cnt;
    bit_n     = bit_idx;
    shift_n   = shift_reg;
    fifo_pop  = 1'b0;
    char_done = 1'b0;
    tx_n      = 1'b1;

    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_n  = fifo_data;
          baud_n   = '0;
          state_n  = START;
        end
      end
      START: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
        end else begin
          baud_n = baud_cnt + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_n  = '0;
          shift_n = {1'b0, shift_reg[7:1]};
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end else begin
          baud_n = baud_cnt + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_n    = '0;
          state_n   = IDLE;
          char_done = 1'b1;
        end else begin
          baud_n = baud_cnt + BAUD_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  // Per-frame pixel counter: advances when a stop bit completes and wraps at
  // the frame size, pulsing frame_done in the same cycle as the wrap.
  always_ff @(posedge clk_200mhz) begin
    if (reset) begin
      pixel_count <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (char_done) begin
        if (pixel_count == FRAME_LAST) begin
          pixel_count <= '0;
          frame_done  <= 1'b1;
        end else begin
          pixel_count <= pixel_count + 10'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_serializer.sv
// tb_pixel_serializer
// Self-checking bench for pixel_serializer with CLKS_PER_BIT=4,
// FRAME_PIXELS=3, FIFO_DEPTH=4. A character-level model predicts every
// output each cycle; a line decoder recovers the transmitted bytes.

module tb_pixel_serializer;

  localparam int CPB         = 4;
  localparam int FRAME       = 3;
  localparam int DEPTH       = 4;
  localparam int CHAR_CYCLES = 10 * CPB;

  logic       clk_200mhz = 1'b0;
  logic       reset      = 1'b1;
  logic [7:0] pixel_in   = 8'h00;
  logic       valid_in   = 1'b0;
  logic       ready_out;
  logic       tx_serial;
  logic       tx_busy;
  logic       frame_done;
  logic [9:0] pixel_count;

  int checks = 0;
  int errors = 0;
  int fd_pulses = 0;
  int fd_count_at_pulse = -1;

  // Model state: pending bytes, the character in flight and its age in cycles
  logic [7:0] m_q[$];
  logic [7:0] acc_log[$];
  logic [7:0] rx_log[$];
  logic [7:0] exp_q[$];
  logic [7:0] m_cur = 8'h00;
  bit         m_in_char = 1'b0;
  bit         m_acc = 1'b0;
  bit         m_fd = 1'b0;
  bit         m_live = 1'b0;
  int         m_t = 0;
  int         m_count = 0;

  // Line decoder state
  bit         rx_active = 1'b0;
  logic       rx_prev = 1'b1;
  int         rx_t = 0;
  logic [7:0] rx_byte = 8'h00;

  logic [39:0] a5_wave;

  pixel_serializer #(
    .CLKS_PER_BIT (CPB),
    .FRAME_PIXELS (FRAME),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk_200mhz  (clk_200mhz),
    .reset       (reset),
    .pixel_in    (pixel_in),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .tx_serial   (tx_serial),
    .tx_busy     (tx_busy),
    .frame_done  (frame_done),
    .pixel_count (pixel_count)
  );

  always #5 clk_200mhz = ~clk_200mhz;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Expected line level from the character age: 1 start bit, 8 data bits
  // LSB first, 1 stop bit, each CPB cycles long.
  function automatic logic modelTx();
    logic [7:0] shifted;
    if (!m_in_char) return 1'b1;
    if (m_t < CPB) return 1'b0;
    if (m_t < 9 * CPB) begin
      shifted = m_cur >> ((m_t - CPB) / CPB);
      return shifted[0];
    end
    return 1'b1;
  endfunction

  // Character-level model, advanced once per rising edge from the inputs
  always @(posedge clk_200mhz) begin
    if (reset) begin
      m_q.delete();
      acc_log.delete();
      rx_log.delete();
      m_in_char = 1'b0;
      m_t       = 0;
      m_count   = 0;
      m_fd      = 1'b0;
      m_live    = 1'b1;
    end else begin
      m_acc = (valid_in === 1'b1) && (m_q.size() < DEPTH);
      m_fd  = 1'b0;
      if (m_in_char) begin
        m_t++;
        if (m_t == CHAR_CYCLES) begin
          m_in_char = 1'b0;
          m_count++;
          if (m_count == FRAME) begin
            m_count = 0;
            m_fd    = 1'b1;
          end
        end
      end else if (m_q.size() > 0) begin
        m_cur     = m_q.pop_front();
        m_in_char = 1'b1;
        m_t       = 0;
      end
      if (m_acc) begin
        m_q.push_back(pixel_in);
        acc_log.push_back(pixel_in);
      end
    end
  end

  // Compare every output with the model on each falling edge
  always @(negedge clk_200mhz) begin
    if (m_live) begin
      checkOutput("tx_serial", 64'(tx_serial), 64'(modelTx()));
      checkOutput("ready_out", 64'(ready_out), 64'(m_q.size() < DEPTH));
      checkOutput("tx_busy", 64'(tx_busy), 64'(m_in_char || (m_q.size() > 0)));
      checkOutput("pixel_count", 64'(pixel_count), 64'(m_count));
      checkOutput("frame_done", 64'(frame_done), 64'(m_fd));
      if (frame_done === 1'b1) begin
        fd_pulses++;
        fd_count_at_pulse = int'(pixel_count);
      end
    end
  end

  // Independent line decoder sampling mid-bit
  always @(negedge clk_200mhz) begin
    if (reset) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (rx_prev === 1'b1 && tx_serial === 1'b0) begin
        rx_active = 1'b1;
        rx_t      = 0;
      end
    end else begin
      rx_t++;
      if (rx_t < 9 * CPB && rx_t > CPB && ((rx_t - CPB / 2) % CPB) == 0) begin
        rx_byte = {tx_serial, rx_byte[7:1]};
      end else if (rx_t == 9 * CPB + CPB / 2) begin
        checkOutput("rx_stop_bit", 64'(tx_serial), 64'd1);
        rx_log.push_back(rx_byte);
        rx_active = 1'b0;
      end
    end
    rx_prev = tx_serial;
  end

  // Offer one pixel from a falling edge and hold it until it is accepted
  task automatic applyStimulus(input logic [7:0] pix);
    logic r;
    int   n;
    n        = 0;
    pixel_in = pix;
    valid_in = 1'b1;
    do begin
      r = ready_out;
      @(negedge clk_200mhz);
      n++;
    end while (r !== 1'b1 && n < 400);
    if (r !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: ready_out=%b after %0d cycles, required 1", r, n);
    end
    valid_in = 1'b0;
  endtask

  task automatic waitIdle(input int limit);
    int n;
    n = 0;
    while (tx_busy !== 1'b0 && n < limit) begin
      @(negedge clk_200mhz);
      n++;
    end
    if (n >= limit) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_timeout: tx_busy=%b after %0d cycles, required 0", tx_busy, limit);
    end
    repeat (3) @(negedge clk_200mhz);
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(negedge clk_200mhz);
    reset = 1'b0;
  endtask

  task automatic checkRx(input string name);
    checkOutput({name, "_count"}, 64'(rx_log.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_log.size(); i++) begin
      checkOutput(name, 64'(rx_log[i]), 64'(exp_q[i]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: still running at %0t, required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;

    // Reset state
    repeat (3) @(negedge clk_200mhz);
    reset = 1'b0;
    checkOutput("reset_tx", 64'(tx_serial), 64'd1);
    checkOutput("reset_ready", 64'(ready_out), 64'd1);
    checkOutput("reset_busy", 64'(tx_busy), 64'd0);
    checkOutput("reset_count", 64'(pixel_count), 64'd0);
    checkOutput("reset_frame_done", 64'(frame_done), 64'd0);

    // Single pixel 0xA5: exact waveform, first sample right after the pop
    applyStimulus(8'hA5);
    for (int i = 0; i < CHAR_CYCLES; i++) begin
      @(negedge clk_200mhz);
      a5_wave = {tx_serial, a5_wave[39:1]};
    end
    checkOutput("a5_waveform", 64'(a5_wave), 64'h00_FF_0F_00_F0_F0);
    @(negedge clk_200mhz);
    checkOutput("a5_count", 64'(pixel_count), 64'd1);
    waitIdle(200);

    // Frame of three pixels: one frame_done pulse with count wrapping to 0
    doReset();
    fd_pulses = 0;
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    applyStimulus(8'h3C);
    waitIdle(600);
    checkOutput("frame_pulses", 64'(fd_pulses), 64'd1);
    checkOutput("frame_wrap_count", 64'(fd_count_at_pulse), 64'd0);
    checkOutput("frame_count_after", 64'(pixel_count), 64'd0);
    exp_q = '{8'h00, 8'hFF, 8'h3C};
    checkRx("frame_bytes");

    // Five back-to-back pixels while a character is already on the line
    acc_log.delete();
    rx_log.delete();
    applyStimulus(8'h11);
    repeat (3) @(negedge clk_200mhz);
    applyStimulus(8'h5A);
    applyStimulus(8'hC3);
    applyStimulus(8'h81);
    applyStimulus(8'h7E);
    checkOutput("ready_low_when_full", 64'(ready_out), 64'd0);
    checkOutput("busy_when_full", 64'(tx_busy), 64'd1);
    applyStimulus(8'h24);
    waitIdle(1000);
    exp_q = '{8'h11, 8'h5A, 8'hC3, 8'h81, 8'h7E, 8'h24};
    checkRx("burst_bytes");

    // Reset during data bit 3 of 0x96 with 0x0F still buffered
    applyStimulus(8'h42);
    waitIdle(200);
    checkOutput("count_before_abort", 64'(pixel_count), 64'd1);
    fd_pulses = 0;
    applyStimulus(8'h96);
    applyStimulus(8'h0F);
    n = 0;
    while (!(m_in_char && m_cur == 8'h96 && m_t == 4 * CPB + 1) && n < 200) begin
      @(negedge clk_200mhz);
      n++;
    end
    checkOutput("abort_reached_bit3", 64'(n < 200), 64'd1);
    checkOutput("abort_line_bit3", 64'(tx_serial), 64'd0);
    reset = 1'b1;
    @(negedge clk_200mhz);
    checkOutput("abort_tx", 64'(tx_serial), 64'd1);
    checkOutput("abort_busy", 64'(tx_busy), 64'd0);
    checkOutput("abort_ready", 64'(ready_out), 64'd1);
    checkOutput("abort_count", 64'(pixel_count), 64'd0);
    checkOutput("abort_frame_done", 64'(frame_done), 64'd0);
    @(negedge clk_200mhz);
    reset = 1'b0;
    repeat (60) @(negedge clk_200mhz);
    checkOutput("abort_stays_idle", 64'(tx_busy), 64'd0);
    checkOutput("abort_no_rx", 64'(rx_log.size()), 64'd0);
    checkOutput("abort_no_pulse", 64'(fd_pulses), 64'd0);

    // Random valid_in against a full buffer
    applyStimulus(8'h33);
    repeat (2) @(negedge clk_200mhz);
    applyStimulus(8'hA0);
    applyStimulus(8'hB1);
    applyStimulus(8'hC2);
    applyStimulus(8'hD3);
    checkOutput("rand_full_ready", 64'(ready_out), 64'd0);
    for (int i = 0; i < 160; i++) begin
      valid_in = 1'($urandom_range(0, 1));
      pixel_in = 8'($urandom);
      @(negedge clk_200mhz);
    end
    valid_in = 1'b0;
    waitIdle(2000);
    exp_q = acc_log;
    checkRx("rand_bytes");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_serializer.md
PIXEL_SERIALIZER -- requirements
Module: pixel_serializer

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 1736, clock cycles per serial bit (115200 baud at 200 MHz).
REQ-002 SHALL provide parameter FRAME_PIXELS, default 961, pixels per frame (31x31 stride-2 pooled image).
REQ-003 SHALL provide parameter FIFO_DEPTH, default 4, input buffer entries (power of two).
REQ-004 SHALL have port clk_200mhz  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port pixel_in  input  8  pooled pixel from pooling stage.
REQ-007 SHALL have port valid_in  input  1  pixel_in valid.
REQ-008 SHALL have port ready_out  output  1  backpressure to pooling stage; high when buffer can accept.
REQ-009 SHALL have port tx_serial  output  1  serial line, idle high.
REQ-010 SHALL have port tx_busy  output  1  high while a character is on the line or the buffer is non-empty.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse at end of last pixel of a frame.
REQ-012 SHALL have port pixel_count  output  10  pixels fully transmitted in current frame.

Function
REQ-013 SHALL accept a pixel on each rising edge where valid_in and ready_out are both high; no other edge writes the buffer.
REQ-014 SHALL drive ready_out = not full, derived from registered occupancy only (no combinational path from valid_in).
REQ-015 SHALL implement a FIFO_DEPTH-entry FIFO with wrap-around read/write pointers; simultaneous push and pop when non-full SHALL keep occupancy unchanged; pop when empty SHALL never occur.
REQ-016 SHALL use a transmit FSM with states IDLE, START, DATA, STOP.
REQ-017 IDLE: tx_serial=1; if FIFO non-empty, pop head into shift register and go to START on the same edge.
REQ-018 START: tx_serial=0 for CLKS_PER_BIT cycles, then DATA.
REQ-019 DATA: send 8 bits LSB first, each held CLKS_PER_BIT cycles, bit index 0..7, then STOP.
REQ-020 STOP: tx_serial=1 for CLKS_PER_BIT cycles, then IDLE; no idle gap is required beyond the one IDLE cycle.
REQ-021 Latency: a pixel accepted into an empty FIFO with FSM in IDLE at edge N SHALL be popped at edge N+1, start bit visible after edge N+1.
REQ-022 pixel_count SHALL increment on the edge STOP completes; on reaching FRAME_PIXELS it SHALL wrap to 0 and frame_done SHALL pulse high that same cycle.
REQ-023 tx_serial, pixel_count and frame_done SHALL be registered outputs.
REQ-024 Baud counter width SHALL be $clog2(CLKS_PER_BIT); bit counter 3 bits.

Reset
REQ-025 While reset is high at an edge: FSM=IDLE, FIFO empty, pointers 0, pixel_count=0, frame_done=0, tx_serial=1, ready_out=1 after release, tx_busy=0.
REQ-026 Reset mid-character SHALL abort immediately; line returns high next cycle; buffered pixels discarded.

Structure
REQ-027 SHALL place FSM state encoding and default CLKS_PER_BIT/FRAME_PIXELS constants in shared package pixel_link_pkg.
REQ-028 SHALL instantiate one sub-module, pixel_fifo, holding storage, pointers and full/empty flags.

Verification (bench CLKS_PER_BIT=4, FRAME_PIXELS=3)
REQ-029 Single pixel 0xA5 into idle block -> tx_serial low 4 cycles, then 1,0,1,0,0,1,0,1 each 4 cycles, high 4 cycles; pixel_count 0->1.
REQ-030 Five back-to-back valid pixels with FIFO_DEPTH=4 -> ready_out low after fourth acceptance until first pop; all five transmitted in order, none lost or duplicated.
REQ-031 Three pixels 0x00,0xFF,0x3C -> frame_done single-cycle pulse at end of third stop bit; pixel_count wraps to 0 that cycle.
REQ-032 Reset asserted during DATA bit 3 -> tx_serial=1 next cycle, FIFO empty, pixel_count=0, no frame_done pulse.
REQ-033 valid_in toggling randomly with ready_out held low by full FIFO -> no writes occur; occupancy never exceeds 4; tx_serial frames remain well-formed.
